connect4_game_fsm: RTL and testbench

- Game-state engine for the Connect4 VGA lab; sits directly upstream of the RGB controller.
- Owns the board, the cursor, the turn and game-over state, and drives them every cycle to the renderer.
- Takes single-cycle, already-debounced button pulses.
- Places pieces with gravity, runs a sequential 4-direction win check, detects draws and supports restart.

---
 rtl/connect4_pkg.sv | 50 +++++
 rtl/connect4_line_counter.sv | 73 +++++++
 rtl/connect4_game_fsm.sv | 204 ++++++++++++++++++++
 tb/tb_connect4_game_fsm.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/connect4_pkg.sv
// Shared types, board geometry and helpers for the Connect4 game-state engine.
package connect4_pkg;

  localparam int unsigned NUM_ROWS = 6;
  localparam int unsigned NUM_COLS = 7;
  localparam int unsigned WIN_LEN  = 4;

  typedef logic [NUM_ROWS-1:0][NUM_COLS-1:0] board_t;

  typedef enum logic [2:0] {
    PLAY,
    DROP,
    CHECK,
    SWITCH,
    GAME_OVER
  } state_t;

  typedef enum logic [1:0] {
    DIR_H,
    DIR_V,
    DIR_D1,
    DIR_D2
  } dir_t;

  localparam logic RED  = 1'b1;
  localparam logic BLUE = 1'b0;

  localparam logic [NUM_COLS-1:0] CURSOR_HOME = 7'b0001000;

  // Column index of a one-hot cursor vector.
  function automatic logic [2:0] onehot_to_col(input logic [NUM_COLS-1:0] oh);
    logic [2:0] col;
    col = '0;
    for (int unsigned i = 0; i < NUM_COLS; i++) begin
      if (oh[i]) col = 3'(i);
    end
    return col;
  endfunction

  // Lowest empty row in a column; returns NUM_ROWS when the column is full.
  function automatic logic [2:0] lowest_free_row(input board_t b, input logic [2:0] col);
    logic [2:0] row;
    row = 3'(NUM_ROWS);
    for (int unsigned r = NUM_ROWS; r > 0; r--) begin
      if (!b[r-1][col]) row = 3'(r - 1);
    end
    return row;
  endfunction

endpackage

// File: rtl/connect4_line_counter.sv
// Combinational run-length counter: contiguous cells owned by one player
// through (row, col) along one direction, looking up to WIN_LEN-1 cells
// each way and stopping at the board edges.
module connect4_line_counter
  import connect4_pkg::*;
(
  input  board_t     tablero,
  input  board_t     fichas,
  input  logic       player,
  input  logic [2:0] row,
  input  logic [2:0] col,
  input  dir_t       dir,
  output logic [2:0] run_len
);

  // Walk both rays from the anchor cell and accumulate the run.
  always_comb begin
    int         dr;
    int         dc;
    int         r;
    int         c;
    int         count;
    logic       fwd_open;
    logic       bwd_open;
    logic [2:0] ri;
    logic [2:0] ci;

    dr = 0;
    dc = 1;
    case (dir)
      DIR_H:   begin dr = 0; dc =  1; end
      DIR_V:   begin dr = 1; dc =  0; end
      DIR_D1:  begin dr = 1; dc =  1; end
      DIR_D2:  begin dr = 1; dc = -1; end
      default: begin dr = 0; dc =  1; end
    endcase

    count    = 1;
    fwd_open = 1'b1;
    bwd_open = 1'b1;
    r        = 0;
    c        = 0;
    ri       = '0;
    ci       = '0;

    for (int unsigned k = 1; k < WIN_LEN; k++) begin
      r  = int'(row) + int'(k) * dr;
      c  = int'(col) + int'(k) * dc;
      ri = r[2:0];
      ci = c[2:0];
      if (fwd_open && r >= 0 && r < int'(NUM_ROWS) && c >= 0 && c < int'(NUM_COLS)
          && tablero[ri][ci] && (fichas[ri][ci] == player)) begin
        count = count + 1;
      end else begin
        fwd_open = 1'b0;
      end

      r  = int'(row) - int'(k) * dr;
      c  = int'(col) - int'(k) * dc;
      ri = r[2:0];
      ci = c[2:0];
      if (bwd_open && r >= 0 && r < int'(NUM_ROWS) && c >= 0 && c < int'(NUM_COLS)
          && tablero[ri][ci] && (fichas[ri][ci] == player)) begin
        count = count + 1;
      end else begin
        bwd_open = 1'b0;
      end
    end

    run_len = (count > 7) ? 3'd7 : count[2:0];
  end

endmodule

// File: rtl/connect4_game_fsm.sv
// Connect4 game-state engine: cursor, gravity drop, sequential four-direction
// win check, draw detection and restart. All outputs are registered.
// Optional turn timeout with auto-drop: define CONNECT4_TURN_TIMEOUT_EN.
module connect4_game_fsm
  import connect4_pkg::*;
`ifdef CONNECT4_TURN_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 250_000_000
)
`endif
(
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_left,
  input  logic                btn_right,
  input  logic                btn_drop,
  input  logic                btn_restart,
  output logic [NUM_COLS-1:0] posicion,
  output board_t              tablero,
  output board_t              fichas,
  output logic                jugador,
  output logic                finJuego,
  output logic                empate,
  output logic                ganador
);

  state_t              state, state_n;
  logic [2:0]          row_q, row_n;
  logic [2:0]          col_q, col_n;
  dir_t                dir_q, dir_n;

  logic [NUM_COLS-1:0] pos_n;
  board_t              board_n;
  board_t              owner_n;
  logic                jug_n;
  logic                fin_n;
  logic                emp_n;
  logic                gan_n;

  logic [2:0]          cur_col;
  logic [2:0]          cur_row;
  logic                cur_full;
  logic                auto_drop;
  logic [2:0]          auto_col;
  logic [2:0]          auto_row;
  logic [2:0]          run_len;

  assign cur_col  = onehot_to_col(posicion);
  assign cur_row  = lowest_free_row(tablero, cur_col);
  assign cur_full = (cur_row == 3'(NUM_ROWS));
  assign auto_row = lowest_free_row(tablero, auto_col);

`ifdef CONNECT4_TURN_TIMEOUT_EN
  logic [31:0] turn_cnt;

  // Turn timer: zero outside PLAY, so it restarts on every entry to PLAY.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn_cnt <= '0;
    end else if (state == PLAY) begin
      turn_cnt <= turn_cnt + 32'd1;
    end else begin
      turn_cnt <= '0;
    end
  end

  assign auto_drop = (state == PLAY) && (turn_cnt == 32'(TIMEOUT_CYCLES - 1));

  // Auto-drop column: cursor column, else the lowest-index column with room.
  always_comb begin
    auto_col = cur_col;
    if (cur_full) begin
      for (int unsigned i = NUM_COLS; i > 0; i--) begin
        if (!tablero[NUM_ROWS-1][i-1]) auto_col = 3'(i - 1);
      end
    end
  end
`else
  assign auto_drop = 1'b0;
  assign auto_col  = cur_col;
`endif

  connect4_line_counter u_line_counter (
    .tablero (tablero),
    .fichas  (fichas),
    .player  (jugador),
    .row     (row_q),
    .col     (col_q),
    .dir     (dir_q),
    .run_len (run_len)
  );

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PLAY;
      row_q    <= '0;
      col_q    <= '0;
      dir_q    <= DIR_H;
      posicion <= CURSOR_HOME;
      tablero  <= '0;
      fichas   <= '0;
      jugador  <= RED;
      finJuego <= 1'b0;
      empate   <= 1'b0;
      ganador  <= BLUE;
    end else begin
      state    <= state_n;
      row_q    <= row_n;
      col_q    <= col_n;
      dir_q    <= dir_n;
      posicion <= pos_n;
      tablero  <= board_n;
      fichas   <= owner_n;
      jugador  <= jug_n;
      finJuego <= fin_n;
      empate   <= emp_n;
      ganador  <= gan_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n = state;
    row_n   = row_q;
    col_n   = col_q;
    dir_n   = dir_q;
    pos_n   = posicion;
    board_n = tablero;
    owner_n = fichas;
    jug_n   = jugador;
    fin_n   = finJuego;
    emp_n   = empate;
    gan_n   = ganador;

    case (state)
      PLAY: begin
        // A drop pulse always suppresses cursor movement, even when its column is full.
        if (btn_drop) begin
          if (!cur_full) begin
            row_n   = cur_row;
            col_n   = cur_col;
            state_n = DROP;
          end
        end else if (auto_drop) begin
          row_n   = auto_row;
          col_n   = auto_col;
          state_n = DROP;
        end else if (btn_left && !btn_right) begin
          if (!posicion[NUM_COLS-1]) pos_n = posicion << 1;
        end else if (btn_right && !btn_left) begin
          if (!posicion[0]) pos_n = posicion >> 1;
        end
      end

      DROP: begin
        board_n[row_q][col_q] = 1'b1;
        owner_n[row_q][col_q] = jugador;
        dir_n   = DIR_H;
        state_n = CHECK;
      end

      CHECK: begin
        if (run_len >= 3'(WIN_LEN)) begin
          fin_n   = 1'b1;
          gan_n   = jugador;
          state_n = GAME_OVER;
        end else if (dir_q == DIR_D2) begin
          if (&tablero[NUM_ROWS-1]) begin
            fin_n   = 1'b1;
            emp_n   = 1'b1;
            state_n = GAME_OVER;
          end else begin
            state_n = SWITCH;
          end
        end else begin
          dir_n = dir_t'(dir_q + 2'd1);
        end
      end

      SWITCH: begin
        jug_n   = ~jugador;
        state_n = PLAY;
      end

      GAME_OVER: begin
        if (btn_restart) begin
          pos_n   = CURSOR_HOME;
          board_n = '0;
          owner_n = '0;
          jug_n   = RED;
          fin_n   = 1'b0;
          emp_n   = 1'b0;
          gan_n   = BLUE;
          dir_n   = DIR_H;
          state_n = PLAY;
        end
      end

      default: state_n = PLAY;
    endcase
  end

endmodule

// File: tb/tb_connect4_game_fsm.sv
// Self-checking bench for connect4_game_fsm: table-driven cursor vectors plus
// hand-written drop, full-column, win, draw and restart sequences.
module tb_connect4_game_fsm;
  import connect4_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                btn_left = 1'b0;
  logic                btn_right = 1'b0;
  logic                btn_drop = 1'b0;
  logic                btn_restart = 1'b0;
  logic [NUM_COLS-1:0] posicion;
  board_t              tablero;
  board_t              fichas;
  logic                jugador;
  logic                finJuego;
  logic                empate;
  logic                ganador;

  always #5 clk = ~clk;

`ifdef CONNECT4_TURN_TIMEOUT_EN
  connect4_game_fsm #(.TIMEOUT_CYCLES(16)) dut (
`else
  connect4_game_fsm dut (
`endif
    .clk         (clk),
    .rst         (rst),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_drop    (btn_drop),
    .btn_restart (btn_restart),
    .posicion    (posicion),
    .tablero     (tablero),
    .fichas      (fichas),
    .jugador     (jugador),
    .finJuego    (finJuego),
    .empate      (empate),
    .ganador     (ganador)
  );

  int     n_checks = 0;
  int     n_pass   = 0;
  board_t m_board;
  board_t m_owner;
  logic   m_jug;
  int     cur;

  typedef struct {
    logic       l;
    logic       r;
    logic [6:0] pos;
  } vec_t;

  vec_t vecs[14];

  int draw_cols[42] = '{0,1,1,0,1,0,0,1,0,1,1,0,
                        2,3,3,2,3,2,2,3,2,3,3,2,
                        4,5,5,4,5,4,6,6,4,6,6,5,4,5,6,4,5,6};
  int diag_cols[10] = '{0,1,1,2,3,2,2,3,4,3};
  int horz_cols[6]  = '{0,0,1,1,2,2};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic press(input logic l, input logic r, input logic d, input logic rs);
    btn_left = l; btn_right = r; btn_drop = d; btn_restart = rs;
    @(negedge clk);
    btn_left = 1'b0; btn_right = 1'b0; btn_drop = 1'b0; btn_restart = 1'b0;
  endtask

  task automatic model_reset();
    m_board = '0;
    m_owner = '0;
    m_jug   = 1'b1;
    cur     = 3;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic move_to(input int col);
    while (cur < col) begin press(1'b1, 1'b0, 1'b0, 1'b0); cur++; end
    while (cur > col) begin press(1'b0, 1'b1, 1'b0, 1'b0); cur--; end
  endtask

  // Place a piece in the bench model (gravity) without touching the DUT.
  task automatic model_place(input int col);
    for (int r = 0; r < 6; r++) begin
      if (!m_board[r][col]) begin
        m_board[r][col] = 1'b1;
        m_owner[r][col] = m_jug;
        break;
      end
    end
  endtask

  // Non-winning move: full 7-cycle round trip back to PLAY.
  task automatic play_move(input int col);
    move_to(col);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (6) @(negedge clk);
    model_place(col);
    m_jug = ~m_jug;
    check("move_tablero", 64'(tablero), 64'(m_board));
    check("move_fichas",  64'(fichas),  64'(m_owner));
    check("move_jugador", 64'(jugador), 64'(m_jug));
    check("move_fin",     64'(finJuego), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 7'b0010000};
    vecs[1]  = '{1'b1, 1'b0, 7'b0100000};
    vecs[2]  = '{1'b1, 1'b0, 7'b1000000};
    vecs[3]  = '{1'b1, 1'b0, 7'b1000000};
    vecs[4]  = '{1'b1, 1'b1, 7'b1000000};
    vecs[5]  = '{1'b0, 1'b1, 7'b0100000};
    vecs[6]  = '{1'b1, 1'b1, 7'b0100000};
    vecs[7]  = '{1'b0, 1'b1, 7'b0010000};
    vecs[8]  = '{1'b0, 1'b1, 7'b0001000};
    vecs[9]  = '{1'b0, 1'b1, 7'b0000100};
    vecs[10] = '{1'b0, 1'b1, 7'b0000010};
    vecs[11] = '{1'b0, 1'b1, 7'b0000001};
    vecs[12] = '{1'b0, 1'b1, 7'b0000001};
    vecs[13] = '{1'b1, 1'b0, 7'b0000010};

    // Reset state.
    do_reset();
    check("rst_posicion", 64'(posicion), 64'h08);
    check("rst_tablero",  64'(tablero),  64'd0);
    check("rst_fichas",   64'(fichas),   64'd0);
    check("rst_jugador",  64'(jugador),  64'd1);
    check("rst_fin",      64'(finJuego), 64'd0);
    check("rst_empate",   64'(empate),   64'd0);
    check("rst_ganador",  64'(ganador),  64'd0);

    // Cursor movement, saturation and simultaneous pulses.
    for (int unsigned i = 0; i < 14; i++) begin
      press(vecs[i].l, vecs[i].r, 1'b0, 1'b0);
      check($sformatf("cursor_vec%0d", i), 64'(posicion), 64'(vecs[i].pos));
    end
    check("cursor_no_board", 64'(tablero), 64'd0);

    // First drop in column 3 with exact latency; cursor frozen outside PLAY.
    do_reset();
    press(1'b0, 1'b0, 1'b1, 1'b0);
    check("drop_pending", 64'(tablero), 64'd0);
    @(negedge clk);
    check("drop_tablero", 64'(tablero), 64'h8);
    check("drop_fichas",  64'(fichas),  64'h8);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("drop_no_early_switch", 64'(jugador), 64'd1);
    @(negedge clk);
    check("drop_switch_7", 64'(jugador), 64'd0);
    check("drop_cursor_frozen", 64'(posicion), 64'h08);
    m_board[0][3] = 1'b1;
    m_owner[0][3] = 1'b1;
    m_jug = 1'b0;
    play_move(3);
    check("drop2_fichas_1_3", 64'(fichas[1][3]), 64'd0);

    // Full column: drop ignored, state stays PLAY (cursor still moves).
    do_reset();
    for (int i = 0; i < 6; i++) play_move(0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    cur = 1;
    check("full_cursor_moves", 64'(posicion), 64'h02);
    check("full_tablero", 64'(tablero), 64'(m_board));
    repeat (6) @(negedge clk);
    check("full_tablero_later", 64'(tablero), 64'(m_board));
    check("full_jugador", 64'(jugador), 64'd1);

    // Horizontal red win in row 0, then GAME_OVER hold and restart.
    do_reset();
    for (int i = 0; i < 6; i++) play_move(horz_cols[i]);
    move_to(3);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    model_place(3);
    @(negedge clk);
    check("hwin_not_yet", 64'(finJuego), 64'd0);
    @(negedge clk);
    check("hwin_fin",     64'(finJuego), 64'd1);
    check("hwin_ganador", 64'(ganador),  64'd1);
    check("hwin_empate",  64'(empate),   64'd0);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (8) @(negedge clk);
    check("over_tablero", 64'(tablero), 64'(m_board));
    check("over_jugador", 64'(jugador), 64'd1);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("over_cursor", 64'(posicion), 64'h08);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    check("restart_posicion", 64'(posicion), 64'h08);
    check("restart_tablero",  64'(tablero),  64'd0);
    check("restart_fichas",   64'(fichas),   64'd0);
    check("restart_jugador",  64'(jugador),  64'd1);
    check("restart_fin",      64'(finJuego), 64'd0);
    check("restart_empate",   64'(empate),   64'd0);
    check("restart_ganador",  64'(ganador),  64'd0);
    press(1'b1, 1'b0, 1'b0, 1'b0);
    check("restart_play", 64'(posicion), 64'h10);

    // Diagonal up-right red win ending at (3,3): found on the third CHECK cycle.
    do_reset();
    for (int i = 0; i < 10; i++) play_move(diag_cols[i]);
    move_to(3);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    check("dwin_not_yet", 64'(finJuego), 64'd0);
    @(negedge clk);
    check("dwin_fin",     64'(finJuego), 64'd1);
    check("dwin_empate",  64'(empate),   64'd0);
    check("dwin_ganador", 64'(ganador),  64'd1);

    // Scripted 42-move draw.
    do_reset();
    for (int i = 0; i < 41; i++) play_move(draw_cols[i]);
    move_to(draw_cols[41]);
    press(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("draw_not_yet", 64'(finJuego), 64'd0);
    @(negedge clk);
    check("draw_fin",     64'(finJuego), 64'd1);
    check("draw_empate",  64'(empate),   64'd1);
    check("draw_tablero", 64'(tablero),  64'h3FF_FFFF_FFFF);
    check("draw_jugador", 64'(jugador),  64'd0);

`ifdef CONNECT4_TURN_TIMEOUT_EN
    // Idle in PLAY: auto-drop accepted on the 16th cycle into the cursor column.
    do_reset();
    repeat (16) @(negedge clk);
    check("tmo_not_yet", 64'(tablero), 64'd0);
    @(negedge clk);
    check("tmo_tablero", 64'(tablero), 64'h8);
    check("tmo_fichas",  64'(fichas),  64'h8);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
